// File: rtl/fifo_byte_packer.sv
// Drains a registered-output synchronous FIFO and packs BYTES_PER_WORD entries into one
// wide word presented on a valid/ready handshake; Flush emits a partial word with a keep mask.
module fifo_byte_packer #(
    parameter int FIFO_WIDTH     = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter int CNT_WIDTH      = $clog2(BYTES_PER_WORD) + 1
) (
    input  logic                                 CLK,
    input  logic                                 rst_n,
    input  logic                                 Fifo_Empty,
    input  logic [FIFO_WIDTH-1:0]                Fifo_Data,
    output logic                                 Fifo_Rd_Req,
    input  logic                                 Flush,
    output logic [FIFO_WIDTH*BYTES_PER_WORD-1:0] Word_out,
    output logic [BYTES_PER_WORD-1:0]            Word_Keep,
    output logic                                 Word_Valid,
    input  logic                                 Word_Ready
);

    localparam int                   WORD_WIDTH = FIFO_WIDTH * BYTES_PER_WORD;
    localparam logic [CNT_WIDTH:0]   LANES_EXT  = (CNT_WIDTH + 1)'(BYTES_PER_WORD);
    localparam logic [CNT_WIDTH-1:0] LAST_LANE  = CNT_WIDTH'(BYTES_PER_WORD - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = {CNT_WIDTH{1'b0}};

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                   state_r, state_next_s;
    logic [CNT_WIDTH-1:0]     count_r, count_next_s;
    logic                     rd_pending_r;
    logic                     flush_pend_r, flush_pend_next_s;
    logic [WORD_WIDTH-1:0]    word_r, word_next_s;
    logic [BYTES_PER_WORD-1:0] keep_r, keep_next_s;
    logic                     valid_r, valid_next_s;
    logic                     rd_req_s;
    logic [CNT_WIDTH:0]       inflight_s;

    // Lanes already captured plus the one still in flight from the FIFO register.
    assign inflight_s = {1'b0, count_r} + {CNT_ZERO, rd_pending_r};

    // Read request: only while filling, never on empty, never past a full word or a pending flush.
    always_comb begin
        rd_req_s = 1'b0;
        if (rst_n && (state_r == FILL) && !Fifo_Empty && !flush_pend_r && (inflight_s < LANES_EXT)) begin
            rd_req_s = 1'b1;
        end else begin
            rd_req_s = 1'b0;
        end
    end

    assign Fifo_Rd_Req = rd_req_s;
    assign Word_out    = word_r;
    assign Word_Keep   = keep_r;
    assign Word_Valid  = valid_r;

    // Next-state logic: lane capture, word completion, flush and output handshake.
    always_comb begin
        state_next_s      = state_r;
        count_next_s      = count_r;
        flush_pend_next_s = flush_pend_r;
        word_next_s       = word_r;
        keep_next_s       = keep_r;
        valid_next_s      = valid_r;
        case (state_r)
            FILL: begin
                if (rd_pending_r) begin
                    for (int i = 0; i < BYTES_PER_WORD; i++) begin
                        if (count_r == CNT_WIDTH'(i)) begin
                            word_next_s[i*FIFO_WIDTH +: FIFO_WIDTH] = Fifo_Data;
                            keep_next_s[i]                          = 1'b1;
                        end else begin
                            keep_next_s[i] = keep_r[i];
                        end
                    end
                    count_next_s = count_r + CNT_ONE;
                end else begin
                    count_next_s = count_r;
                end
                // A completing capture wins over any flush, so no empty word follows a full one.
                if (rd_pending_r && (count_r == LAST_LANE)) begin
                    state_next_s      = HOLD;
                    valid_next_s      = 1'b1;
                    flush_pend_next_s = 1'b0;
                end else if (flush_pend_r && !rd_pending_r && (count_r != CNT_ZERO)) begin
                    state_next_s      = HOLD;
                    valid_next_s      = 1'b1;
                    flush_pend_next_s = 1'b0;
                end else if (Flush && (inflight_s != {1'b0, CNT_ZERO})) begin
                    flush_pend_next_s = 1'b1;
                end else begin
                    flush_pend_next_s = flush_pend_r;
                end
            end
            HOLD: begin
                if (Word_Ready) begin
                    state_next_s = FILL;
                    count_next_s = CNT_ZERO;
                    word_next_s  = {WORD_WIDTH{1'b0}};
                    keep_next_s  = {BYTES_PER_WORD{1'b0}};
                    valid_next_s = 1'b0;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s      = FILL;
                count_next_s      = CNT_ZERO;
                flush_pend_next_s = 1'b0;
                word_next_s       = {WORD_WIDTH{1'b0}};
                keep_next_s       = {BYTES_PER_WORD{1'b0}};
                valid_next_s      = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= FILL;
            count_r      <= CNT_ZERO;
            rd_pending_r <= 1'b0;
            flush_pend_r <= 1'b0;
            word_r       <= {WORD_WIDTH{1'b0}};
            keep_r       <= {BYTES_PER_WORD{1'b0}};
            valid_r      <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            count_r      <= count_next_s;
            rd_pending_r <= rd_req_s;
            flush_pend_r <= flush_pend_next_s;
            word_r       <= word_next_s;
            keep_r       <= keep_next_s;
            valid_r      <= valid_next_s;
        end
    end

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Directed bench for fifo_byte_packer with a small registered-output FIFO model upstream.
module tb_fifo_byte_packer;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        Fifo_Empty;
    logic [7:0]  Fifo_Data = 8'h00;
    logic        Fifo_Rd_Req;
    logic        Flush;
    logic [31:0] Word_out;
    logic [3:0]  Word_Keep;
    logic        Word_Valid;
    logic        Word_Ready;

    logic [7:0] mem [0:63];
    int wr_ptr     = 0;
    int rd_ptr     = 0;
    int empty_viol = 0;
    int hs_cnt     = 0;
    int n_checks   = 0;
    int n_fail     = 0;

    fifo_byte_packer dut (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .Fifo_Empty (Fifo_Empty),
        .Fifo_Data  (Fifo_Data),
        .Fifo_Rd_Req(Fifo_Rd_Req),
        .Flush      (Flush),
        .Word_out   (Word_out),
        .Word_Keep  (Word_Keep),
        .Word_Valid (Word_Valid),
        .Word_Ready (Word_Ready)
    );

    always #5 CLK = ~CLK;

    assign Fifo_Empty = (rd_ptr == wr_ptr);

    // FIFO model: data register updates on an accepted read; also tracks handshakes.
    always @(posedge CLK) begin
        if (Fifo_Rd_Req) begin
            if (Fifo_Empty) begin
                empty_viol <= empty_viol + 1;
            end else begin
                Fifo_Data <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1;
            end
        end
        if (Word_Valid && Word_Ready) begin
            hs_cnt <= hs_cnt + 1;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr] = d;
        wr_ptr++;
    endtask

    // Called at a negedge; steps negedges until Word_Valid or the budget runs out.
    task automatic wait_valid(input string tag, input int budget, output int cyc);
        cyc = 0;
        while (Word_Valid !== 1'b1 && cyc < budget) begin
            @(negedge CLK);
            cyc++;
        end
        check_val({tag, "_valid"}, {63'd0, Word_Valid}, 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int base;
        int bad;
        int hs0;

        rst_n      = 1'b0;
        Flush      = 1'b0;
        Word_Ready = 1'b1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        repeat (5) @(negedge CLK);
        check_val("rst_rd_req", {63'd0, Fifo_Rd_Req}, 64'd0);
        check_val("rst_valid",  {63'd0, Word_Valid},  64'd0);
        check_val("rst_word",   {32'd0, Word_out},    64'd0);
        check_val("rst_keep",   {60'd0, Word_Keep},   64'd0);

        // Full word with continuous reads: valid five cycles after the first request.
        rst_n = 1'b1;
        wait_valid("full", 20, cyc);
        check_val("full_latency", 64'(cyc), 64'd5);
        check_val("full_word", {32'd0, Word_out}, 64'h44332211);
        check_val("full_keep", {60'd0, Word_Keep}, 64'hF);
        check_val("full_reads", 64'(rd_ptr), 64'd4);
        @(negedge CLK);
        check_val("full_one_cycle", {63'd0, Word_Valid}, 64'd0);

        // Backpressure: word held stable, no reads in HOLD.
        Word_Ready = 1'b0;
        base = rd_ptr;
        for (int i = 1; i <= 8; i++) push(8'(i));
        wait_valid("bp1", 20, cyc);
        check_val("bp1_word", {32'd0, Word_out}, 64'h04030201);
        check_val("bp1_reads", 64'(rd_ptr - base), 64'd4);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (Word_out !== 32'h04030201 || Word_Valid !== 1'b1 || Fifo_Rd_Req !== 1'b0 || Word_Keep !== 4'hF) bad++;
            @(negedge CLK);
        end
        check_val("bp_hold_stable", 64'(bad), 64'd0);
        check_val("bp_hold_reads", 64'(rd_ptr - base), 64'd4);
        Word_Ready = 1'b1;
        @(negedge CLK);
        check_val("bp_release", {63'd0, Word_Valid}, 64'd0);
        wait_valid("bp2", 20, cyc);
        check_val("bp2_word", {32'd0, Word_out}, 64'h08070605);
        check_val("bp2_keep", {60'd0, Word_Keep}, 64'hF);
        @(negedge CLK);

        // Partial flush of two lanes, then a flush with nothing captured.
        push(8'hAA); push(8'hBB);
        repeat (8) @(negedge CLK);
        check_val("pf_no_early", {63'd0, Word_Valid}, 64'd0);
        Flush = 1'b1;
        @(negedge CLK);
        Flush = 1'b0;
        wait_valid("pf", 10, cyc);
        check_val("pf_word", {32'd0, Word_out}, 64'h0000BBAA);
        check_val("pf_keep", {60'd0, Word_Keep}, 64'h3);
        @(negedge CLK);
        hs0 = hs_cnt;
        Flush = 1'b1;
        @(negedge CLK);
        Flush = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (Word_Valid !== 1'b0) bad++;
            @(negedge CLK);
        end
        check_val("pf_empty_flush_valid", 64'(bad), 64'd0);
        check_val("pf_empty_flush_hs", 64'(hs_cnt - hs0), 64'd0);

        // Flush while the third read is still in flight: no fourth read, three lanes kept.
        base = rd_ptr;
        push(8'hE1); push(8'hE2); push(8'hE3);
        cyc = 0;
        while ((rd_ptr - base) < 3 && cyc < 20) begin
            @(negedge CLK);
            cyc++;
        end
        check_val("fp_three_reads", 64'(rd_ptr - base), 64'd3);
        Flush = 1'b1;
        @(negedge CLK);
        Flush = 1'b0;
        push(8'hE4);
        wait_valid("fp", 10, cyc);
        check_val("fp_word", {32'd0, Word_out}, 64'h00E3E2E1);
        check_val("fp_keep", {60'd0, Word_Keep}, 64'h7);
        check_val("fp_no_fourth_read", 64'(rd_ptr - base), 64'd3);
        @(negedge CLK);

        // Reset mid-word: E4 and 0x55 captured, then reset discards them.
        push(8'h55);
        repeat (6) @(negedge CLK);
        check_val("rm_partial_keep", {60'd0, Word_Keep}, 64'h3);
        check_val("rm_no_valid", {63'd0, Word_Valid}, 64'd0);
        rst_n = 1'b0;
        @(negedge CLK);
        check_val("rm_rst_word", {32'd0, Word_out}, 64'd0);
        check_val("rm_rst_keep", {60'd0, Word_Keep}, 64'd0);
        @(negedge CLK);
        rst_n = 1'b1;
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        wait_valid("rm", 20, cyc);
        check_val("rm_word", {32'd0, Word_out}, 64'hC4C3C2C1);
        check_val("rm_keep", {60'd0, Word_Keep}, 64'hF);
        @(negedge CLK);

        check_val("rd_while_empty", 64'(empty_viol), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
